m_tick_gen_multi: RTL and testbench

Multi-channel, runtime-programmable tick generator. It is the next generation of the single fixed-ratio divider in the matrix display controller. Each channel produces a one-cycle enable pulse (tick) and a 50%-duty square output (sq) from the system clock. All channels are driven by one shared configuration port, and divisor changes take effect glitch-free. Typical consumers are the row scan, PWM brightness and animation frame timers.

---
 rtl/m_tick_gen_multi.sv | 155 +++++++++++++++
 tb/tb_m_tick_gen_multi.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_tick_gen_multi.sv
// Multi-channel programmable tick generator: per-channel tick pulse
// and 50% square output, divisors reprogrammed glitch-free at runtime.

module m_tick_gen_ch #(
  parameter int CNT_W       = 24,
  parameter int DEFAULT_DIV = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] pend_div;

  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] div_n;
  logic [CNT_W-1:0] pdiv_n;
  logic             pend_n;
  logic             tick_n;
  logic             sq_n;
  logic             tc;

  // div_reg is never 0, so div_reg-1 cannot wrap
  assign tc = (cnt == div_reg - ONE);

  always_comb begin
    cnt_n  = cnt;
    div_n  = div_reg;
    pdiv_n = pend_div;
    pend_n = pend;
    tick_n = 1'b0;
    sq_n   = sq;
    if (sync_clr) begin
      cnt_n  = '0;
      sq_n   = 1'b0;
      pend_n = 1'b0;
      if (wr) begin
        div_n = wr_div;
      end else if (pend) begin
        div_n = pend_div;
      end
    end else if (!en) begin
      if (wr) begin
        div_n  = wr_div;
        cnt_n  = '0;
        pend_n = 1'b0;
      end
    end else begin
      if (tc) begin
        cnt_n  = '0;
        tick_n = 1'b1;
        sq_n   = ~sq;
        if (pend) begin
          div_n  = pend_div;
          pend_n = 1'b0;
        end
      end else begin
        cnt_n = cnt + ONE;
      end
      // a write on the terminal edge waits for the following period
      if (wr) begin
        pdiv_n = wr_div;
        pend_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div_reg  <= DEF;
      pend_div <= DEF;
      pend     <= 1'b0;
      tick     <= 1'b0;
      sq       <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      div_reg  <= div_n;
      pend_div <= pdiv_n;
      pend     <= pend_n;
      tick     <= tick_n;
      sq       <= sq_n;
    end
  end

endmodule

module m_tick_gen_multi #(
  parameter  int CHANNELS    = 4,
  parameter  int CNT_W       = 24,
  parameter  int DEFAULT_DIV = 1_000_000,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync_clr,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] cfg_pend,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] sq
);

  localparam logic [CH_W:0]    CH_LIM = CHANNELS[CH_W:0];
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic                ch_ok;
  logic [CNT_W-1:0]    wr_div;
  logic [CHANNELS-1:0] wr;

  assign ch_ok  = ({1'b0, cfg_ch} < CH_LIM);
  assign wr_div = (cfg_div == '0) ? ONE : cfg_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we & ~ch_ok;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign wr[i] = cfg_we & ch_ok & (cfg_ch == CH_W'(i));

    m_tick_gen_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .sync_clr (sync_clr),
      .wr       (wr[i]),
      .wr_div   (wr_div),
      .tick     (tick[i]),
      .sq       (sq[i]),
      .pend     (cfg_pend[i])
    );
  end

endmodule

// File: tb/tb_m_tick_gen_multi.sv
// Directed bench for m_tick_gen_multi: 3 channels, 8-bit counters,
// reset divisor 5.

module tb_m_tick_gen_multi;

  logic       clk;
  logic       rst;
  logic [2:0] en;
  logic       sync_clr;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_err;
  logic [2:0] cfg_pend;
  logic [2:0] tick;
  logic [2:0] sq;

  int errors = 0;
  int checks = 0;

  m_tick_gen_multi #(
    .CHANNELS    (3),
    .CNT_W       (8),
    .DEFAULT_DIV (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_err  (cfg_err),
    .cfg_pend (cfg_pend),
    .tick     (tick),
    .sq       (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr_cfg(input logic [1:0] ch, input logic [7:0] d);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = d;
    cyc();
    cfg_we  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0; sync_clr = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (tick !== 3'b000) begin
      errors++; $display("FAIL rst_tick got=%b exp=000", tick);
    end
    checks++;
    if (sq !== 3'b000) begin
      errors++; $display("FAIL rst_sq got=%b exp=000", sq);
    end
    checks++;
    if (cfg_pend !== 3'b000) begin
      errors++; $display("FAIL rst_pend got=%b exp=000", cfg_pend);
    end
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL rst_err got=%b exp=0", cfg_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_default_div();
    logic [2:0] et, es;
    en = 3'b001;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      et = (k % 5 == 0) ? 3'b001 : 3'b000;
      es = {2'b00, ((k / 5) % 2) == 1};
      checks++;
      if (tick !== et) begin
        errors++; $display("FAIL t1_tick k=%0d got=%b exp=%b", k, tick, et);
      end
      checks++;
      if (sq !== es) begin
        errors++; $display("FAIL t1_sq k=%0d got=%b exp=%b", k, sq, es);
      end
    end
    en = 3'b000;
  endtask

  task automatic test_pending_write();
    logic et, ep, es;
    int n;
    en = 3'b010;
    cyc(); cyc();
    wr_cfg(2'd1, 8'd3);
    checks++;
    if (cfg_pend !== 3'b010 || tick !== 3'b000) begin
      errors++;
      $display("FAIL t2_wr pend=%b tick=%b exp pend=010 tick=000",
               cfg_pend, tick);
    end
    for (int k = 1; k <= 8; k++) begin
      cyc();
      et = (k == 2 || k == 5 || k == 8);
      ep = (k < 2);
      n  = (k >= 2) ? (k - 2) / 3 + 1 : 0;
      es = (n % 2) == 1;
      checks++;
      if (tick !== {1'b0, et, 1'b0}) begin
        errors++; $display("FAIL t2_tick k=%0d got=%b exp=%b", k, tick, {1'b0, et, 1'b0});
      end
      checks++;
      if (cfg_pend[1] !== ep) begin
        errors++; $display("FAIL t2_pend k=%0d got=%b exp=%b", k, cfg_pend[1], ep);
      end
      checks++;
      if (sq[1] !== es) begin
        errors++; $display("FAIL t2_sq k=%0d got=%b exp=%b", k, sq[1], es);
      end
    end
    en = 3'b000;
  endtask

  task automatic test_enable_gap();
    en = 3'b001;
    cyc(); cyc(); cyc();
    en = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      checks++;
      if (tick !== 3'b000 || sq[0] !== 1'b1) begin
        errors++;
        $display("FAIL t3_gap k=%0d tick=%b sq0=%b exp tick=000 sq0=1", k, tick, sq[0]);
      end
    end
    en = 3'b001;
    cyc();
    checks++;
    if (tick !== 3'b000) begin
      errors++; $display("FAIL t3_early got=%b exp=000", tick);
    end
    cyc();
    checks++;
    if (tick !== 3'b001 || sq[0] !== 1'b0) begin
      errors++;
      $display("FAIL t3_resume tick=%b sq0=%b exp tick=001 sq0=0", tick, sq[0]);
    end
    en = 3'b000;
    cyc();
    checks++;
    if (tick !== 3'b000) begin
      errors++; $display("FAIL t3_off got=%b exp=000", tick);
    end
  endtask

  task automatic test_div_zero_one();
    wr_cfg(2'd2, 8'd0);
    checks++;
    if (cfg_pend !== 3'b000 || tick !== 3'b000) begin
      errors++;
      $display("FAIL t4_wr0 pend=%b tick=%b exp 000 000", cfg_pend, tick);
    end
    en = 3'b100;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      checks++;
      if (tick !== 3'b100 || sq[2] !== logic'(k % 2)) begin
        errors++;
        $display("FAIL t4_div0 k=%0d tick=%b sq2=%b exp tick=100 sq2=%0d",
                 k, tick, sq[2], k % 2);
      end
    end
    en = 3'b000;
    cyc();
    wr_cfg(2'd2, 8'd1);
    en = 3'b100;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      checks++;
      if (tick !== 3'b100 || sq[2] !== logic'(k % 2)) begin
        errors++;
        $display("FAIL t4_div1 k=%0d tick=%b sq2=%b exp tick=100 sq2=%0d",
                 k, tick, sq[2], k % 2);
      end
    end
    en = 3'b000;
    cyc();
  endtask

  task automatic test_sync_clr();
    logic [2:0] et;
    wr_cfg(2'd0, 8'd4);
    wr_cfg(2'd2, 8'd4);
    en = 3'b001;
    repeat (5) cyc();
    en = 3'b101;
    cyc();
    checks++;
    if (sq !== 3'b111) begin
      errors++; $display("FAIL t5_pre_sq got=%b exp=111", sq);
    end
    sync_clr = 1'b1;
    cyc();
    sync_clr = 1'b0;
    checks++;
    if (sq !== 3'b000 || tick !== 3'b000) begin
      errors++;
      $display("FAIL t5_clr sq=%b tick=%b exp 000 000", sq, tick);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      et = (k == 4) ? 3'b101 : 3'b000;
      checks++;
      if (tick !== et) begin
        errors++; $display("FAIL t5_align k=%0d got=%b exp=%b", k, tick, et);
      end
    end
    checks++;
    if (sq !== 3'b101) begin
      errors++; $display("FAIL t5_sq got=%b exp=101", sq);
    end
    en = 3'b000;
  endtask

  task automatic test_cfg_err();
    logic [2:0] et;
    wr_cfg(2'd3, 8'd7);
    checks++;
    if (cfg_err !== 1'b1 || cfg_pend !== 3'b000) begin
      errors++;
      $display("FAIL t5_err err=%b pend=%b exp 1 000", cfg_err, cfg_pend);
    end
    cyc();
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL t5_err_drop got=%b exp=0", cfg_err);
    end
    en = 3'b111;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      et = (k == 3) ? 3'b010 : (k == 4) ? 3'b101 : 3'b000;
      checks++;
      if (tick !== et) begin
        errors++; $display("FAIL t5_nochg k=%0d got=%b exp=%b", k, tick, et);
      end
    end
    en = 3'b000;
  endtask

  task automatic test_async_reset();
    logic [2:0] et;
    en = 3'b001;
    repeat (3) cyc();
    wr_cfg(2'd0, 8'd2);
    checks++;
    if (tick !== 3'b001 || cfg_pend !== 3'b001 || sq[0] !== 1'b1) begin
      errors++;
      $display("FAIL t6_tc_wr tick=%b pend=%b sq0=%b exp 001 001 1",
               tick, cfg_pend, sq[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tick !== 3'b000 || sq !== 3'b000 || cfg_pend !== 3'b000) begin
      errors++;
      $display("FAIL t6_async tick=%b sq=%b pend=%b exp 000 000 000",
               tick, sq, cfg_pend);
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 3'b001;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      et = (k == 5) ? 3'b001 : 3'b000;
      checks++;
      if (tick !== et) begin
        errors++; $display("FAIL t6_default k=%0d got=%b exp=%b", k, tick, et);
      end
    end
    en = 3'b000;
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_pending_write();
    test_enable_gap();
    test_div_zero_one();
    test_sync_clr();
    test_cfg_err();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
